// File: rtl/riscv_core_me_pkg.sv
// Shared encodings and decode helpers for the memory-access (ME) stage.
package riscv_core_me_pkg;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LBU  = 4'd4;
    localparam logic [3:0] MEMOP_LHU  = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic [2:0] BRANCHOP_NONE = 3'd0;
    localparam logic [2:0] BRANCHOP_BR_Z = 3'd1;
    localparam logic [2:0] BRANCHOP_BR_NZ = 3'd2;
    localparam logic [2:0] BRANCHOP_JUMP = 3'd3;

    localparam logic [1:0] RFWT_SEL_ALU  = 2'd0;
    localparam logic [1:0] RFWT_SEL_MEM  = 2'd1;
    localparam logic [1:0] RFWT_SEL_PC4  = 2'd2;
    localparam logic [1:0] RFWT_SEL_ALU2 = 2'd3;

    typedef enum logic [1:0] {
        ME_IDLE = 2'd0,
        ME_REQ  = 2'd1,
        ME_WAIT = 2'd2
    } me_state_e;

    function automatic logic is_load(input logic [3:0] memop);
        logic r;
        case (memop)
            MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [3:0] memop);
        logic r;
        case (memop)
            MEMOP_SB, MEMOP_SH, MEMOP_SW: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [3:0] memop, input logic [1:0] addrLo);
        logic r;
        case (memop)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: r = addrLo[0];
            MEMOP_LW, MEMOP_SW:            r = (addrLo != 2'b00);
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_core_me_align.sv
// Store lane replication / byte enables and load byte-half extraction with extension.
module riscv_core_me_align
    import riscv_core_me_pkg::*;
(
    input  logic [3:0]  memop_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] wtdat_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] loadData_o
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Store side: replicate the store value across lanes and enable only the addressed bytes.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wtdat_i;
        case (memop_i)
            MEMOP_SB: begin
                be_o    = 4'b0001 << addrLo_i;
                wdata_o = {4{wtdat_i[7:0]}};
            end
            MEMOP_SH: begin
                be_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wtdat_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wtdat_i;
            end
        endcase
    end

    // Load side: pick the addressed byte or half of the returned word, then extend.
    always_comb begin
        case (addrLo_i)
            2'd0:    loadByte = rdata_i[7:0];
            2'd1:    loadByte = rdata_i[15:8];
            2'd2:    loadByte = rdata_i[23:16];
            default: loadByte = rdata_i[31:24];
        endcase
        loadHalf = addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (memop_i)
            MEMOP_LB:  loadData_o = {{24{loadByte[7]}}, loadByte};
            MEMOP_LBU: loadData_o = {24'd0, loadByte};
            MEMOP_LH:  loadData_o = {{16{loadHalf[15]}}, loadHalf};
            MEMOP_LHU: loadData_o = {16'd0, loadHalf};
            default:   loadData_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_core_me_stage.sv
// Memory-access stage: branch resolution, dmem handshake FSM with watchdog, W-stage registers.
module riscv_core_me_stage
    import riscv_core_me_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            me_valid,
    input  logic [XLEN-1:0] r_me_alu_Q,
    input  logic [XLEN-1:0] r_me_bradd_Q,
    input  logic [2:0]      r_me_branchop_Q,
    input  logic [3:0]      r_me_memop_Q,
    input  logic [XLEN-1:0] r_me_pc_Q,
    input  logic [4:0]      r_me_rd_Q,
    input  logic            r_me_regwrite_Q,
    input  logic [1:0]      r_me_rfwt_sel_Q,
    input  logic [XLEN-1:0] r_me_wtdat_Q,
    input  logic            r_me_zero_Q,
    output logic            me_stall,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_regwrite,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    me_state_e       state_q, state_d;
    logic [CW-1:0]   waitCnt_q, waitCnt_d;
    logic            wbValid_q, wbRegwrite_q, wbErr_q;
    logic [4:0]      wbRd_q;
    logic [XLEN-1:0] wbData_q;

    logic            isLoad, isStore, misaligned, alignedMem;
    logic            rspHit, timeout, retire, brCond, retireErr;
    logic [XLEN-1:0] loadData, wbDataNext;

    assign isLoad     = is_load(r_me_memop_Q);
    assign isStore    = is_store(r_me_memop_Q);
    assign misaligned = (isLoad | isStore) & is_misaligned(r_me_memop_Q, r_me_alu_Q[1:0]);
    assign alignedMem = (isLoad | isStore) & ~misaligned;

    // A response only counts once the request has been accepted; the watchdog fires on its last cycle.
    assign rspHit  = (state_q == ME_WAIT) & dmem_rsp_valid;
    assign timeout = (state_q != ME_IDLE) & (waitCnt_q == CW'(MAX_WAIT - 1)) & ~rspHit;

    assign me_stall = me_valid & alignedMem & ~rspHit & ~timeout;
    assign retire   = me_valid & ~me_stall;
    assign retireErr = misaligned | timeout;

    assign dmem_req_valid = ((state_q == ME_IDLE) & me_valid & alignedMem) |
                            ((state_q == ME_REQ) & ~timeout);
    assign dmem_addr      = {r_me_alu_Q[XLEN-1:2], 2'b00};
    assign dmem_we        = isStore;

    riscv_core_me_align u_align (
        .memop_i    (r_me_memop_Q),
        .addrLo_i   (r_me_alu_Q[1:0]),
        .wtdat_i    (r_me_wtdat_Q),
        .rdata_i    (dmem_rdata),
        .be_o       (dmem_be),
        .wdata_o    (dmem_wdata),
        .loadData_o (loadData)
    );

    // Branch condition decode; the redirect only fires on a retiring instruction.
    always_comb begin
        case (r_me_branchop_Q)
            BRANCHOP_BR_Z:  brCond = r_me_zero_Q;
            BRANCHOP_BR_NZ: brCond = ~r_me_zero_Q;
            BRANCHOP_JUMP:  brCond = 1'b1;
            default:        brCond = 1'b0;
        endcase
    end

    assign br_taken  = retire & brCond;
    assign br_target = r_me_bradd_Q;

    // Write-back data source select; MEM select only yields load data for actual loads.
    always_comb begin
        case (r_me_rfwt_sel_Q)
            RFWT_SEL_MEM: wbDataNext = isLoad ? loadData : r_me_alu_Q;
            RFWT_SEL_PC4: wbDataNext = r_me_pc_Q + XLEN'(4);
            default:      wbDataNext = r_me_alu_Q;
        endcase
    end

    // Transaction FSM next state and watchdog counter; the counter runs only while outstanding.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            ME_IDLE: begin
                waitCnt_d = '0;
                if (me_valid && alignedMem) begin
                    state_d = dmem_req_ready ? ME_WAIT : ME_REQ;
                end
            end
            ME_REQ: begin
                if (timeout) begin
                    state_d   = ME_IDLE;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                    if (dmem_req_ready) begin
                        state_d = ME_WAIT;
                    end
                end
            end
            ME_WAIT: begin
                if (rspHit || timeout) begin
                    state_d   = ME_IDLE;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ME_IDLE;
                waitCnt_d = '0;
            end
        endcase
    end

    // State, watchdog and W-stage registers; reset abandons any outstanding transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ME_IDLE;
            waitCnt_q    <= '0;
            wbValid_q    <= 1'b0;
            wbRd_q       <= '0;
            wbRegwrite_q <= 1'b0;
            wbData_q     <= '0;
            wbErr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            wbValid_q <= retire;
            if (retire) begin
                wbRd_q       <= r_me_rd_Q;
                wbRegwrite_q <= r_me_regwrite_Q & ~isStore & ~retireErr & (r_me_rd_Q != 5'd0);
                wbData_q     <= wbDataNext;
                wbErr_q      <= retireErr;
            end
        end
    end

    assign wb_valid    = wbValid_q;
    assign wb_rd       = wbRd_q;
    assign wb_regwrite = wbRegwrite_q;
    assign wb_data     = wbData_q;
    assign wb_err      = wbErr_q;

endmodule

// File: tb/tb_riscv_core_me_stage.sv
// Directed bench for the ME stage: single-cycle vector table plus multi-cycle dmem sequences.
module tb_riscv_core_me_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        me_valid;
    logic [31:0] r_me_alu_Q, r_me_bradd_Q, r_me_pc_Q, r_me_wtdat_Q;
    logic [2:0]  r_me_branchop_Q;
    logic [3:0]  r_me_memop_Q;
    logic [4:0]  r_me_rd_Q;
    logic        r_me_regwrite_Q;
    logic [1:0]  r_me_rfwt_sel_Q;
    logic        r_me_zero_Q;
    logic        me_stall, br_taken;
    logic [31:0] br_target;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_regwrite, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checkCount = 0;
    int failCount  = 0;

    riscv_core_me_stage #(.XLEN(32), .MAX_WAIT(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .me_valid        (me_valid),
        .r_me_alu_Q      (r_me_alu_Q),
        .r_me_bradd_Q    (r_me_bradd_Q),
        .r_me_branchop_Q (r_me_branchop_Q),
        .r_me_memop_Q    (r_me_memop_Q),
        .r_me_pc_Q       (r_me_pc_Q),
        .r_me_rd_Q       (r_me_rd_Q),
        .r_me_regwrite_Q (r_me_regwrite_Q),
        .r_me_rfwt_sel_Q (r_me_rfwt_sel_Q),
        .r_me_wtdat_Q    (r_me_wtdat_Q),
        .r_me_zero_Q     (r_me_zero_Q),
        .me_stall        (me_stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_addr       (dmem_addr),
        .dmem_we         (dmem_we),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rsp_valid  (dmem_rsp_valid),
        .dmem_rdata      (dmem_rdata),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_regwrite     (wb_regwrite),
        .wb_data         (wb_data),
        .wb_err          (wb_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  memop;
        logic [2:0]  brop;
        logic [31:0] alu;
        logic [31:0] bradd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic        zero;
        logic        expBr;
        logic        expErr;
        logic        expRw;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] memop, input logic [2:0] brop, input logic [31:0] alu,
                                 input logic [31:0] bradd, input logic [31:0] pc, input logic [4:0] rd,
                                 input logic rw, input logic [1:0] sel, input logic zero, input logic [31:0] wtdat);
        me_valid        = 1'b1;
        r_me_memop_Q    = memop;
        r_me_branchop_Q = brop;
        r_me_alu_Q      = alu;
        r_me_bradd_Q    = bradd;
        r_me_pc_Q       = pc;
        r_me_rd_Q       = rd;
        r_me_regwrite_Q = rw;
        r_me_rfwt_sel_Q = sel;
        r_me_zero_Q     = zero;
        r_me_wtdat_Q    = wtdat;
    endtask

    // Aligned memory op with a JUMP attached: redirect must wait for the retire cycle.
    task automatic memTxn(input string name, input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wtdat,
                          input logic [31:0] rdata, input int readyWait, input int rspWait, input logic [31:0] expAddr,
                          input logic expWe, input logic [3:0] expBe, input logic [31:0] expWdata,
                          input logic [1:0] sel, input logic [31:0] expData, input logic expRw);
        applyStimulus(op, 3'd3, alu, 32'h0000_0800, 32'h40, 5'd9, 1'b1, sel, 1'b0, wtdat);
        dmem_rdata     = rdata;
        dmem_rsp_valid = 1'b0;
        for (int i = 0; i <= readyWait; i++) begin
            dmem_req_ready = (i == readyWait);
            #1;
            checkOutput({name, " req stall"}, {31'd0, me_stall}, 32'd1);
            checkOutput({name, " req br"}, {31'd0, br_taken}, 32'd0);
            checkOutput({name, " req valid"}, {31'd0, dmem_req_valid}, 32'd1);
            checkOutput({name, " addr"}, dmem_addr, expAddr);
            checkOutput({name, " we"}, {31'd0, dmem_we}, {31'd0, expWe});
            checkOutput({name, " be"}, {28'd0, dmem_be}, {28'd0, expBe});
            if (expWe) checkOutput({name, " wdata"}, dmem_wdata, expWdata);
            @(posedge CLK); #1;
        end
        dmem_req_ready = 1'b0;
        for (int j = 0; j <= rspWait; j++) begin
            dmem_rsp_valid = (j == rspWait);
            #1;
            checkOutput({name, " wait stall"}, {31'd0, me_stall}, {31'd0, (j != rspWait)});
            checkOutput({name, " wait br"}, {31'd0, br_taken}, {31'd0, (j == rspWait)});
            checkOutput({name, " wait reqvalid"}, {31'd0, dmem_req_valid}, 32'd0);
            checkOutput({name, " wait wbvalid"}, {31'd0, wb_valid}, 32'd0);
            @(posedge CLK); #1;
        end
        me_valid       = 1'b0;
        dmem_rsp_valid = 1'b0;
        checkOutput({name, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        checkOutput({name, " wb_rd"}, {27'd0, wb_rd}, 32'd9);
        checkOutput({name, " wb_regwrite"}, {31'd0, wb_regwrite}, {31'd0, expRw});
        checkOutput({name, " wb_err"}, {31'd0, wb_err}, 32'd0);
        checkOutput({name, " wb_data"}, wb_data, expData);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vecs[0]  = '{4'd0, 3'd0, 32'h0000_1234, 32'h0,        32'h0000_0010, 5'd5,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{4'd0, 3'd0, 32'h0000_0077, 32'h0,        32'h0000_0080, 5'd7,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0084};
        vecs[2]  = '{4'd0, 3'd0, 32'hDEAD_0000, 32'h0,        32'h0000_0000, 5'd0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000};
        vecs[3]  = '{4'd0, 3'd0, 32'h0000_0055, 32'h0,        32'h0000_0000, 5'd6,  1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055};
        vecs[4]  = '{4'd0, 3'd2, 32'h0000_0001, 32'h0000_0400, 32'h0000_0020, 5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001};
        vecs[5]  = '{4'd0, 3'd2, 32'h0000_0000, 32'h0000_0400, 32'h0000_0020, 5'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{4'd0, 3'd1, 32'h0000_0000, 32'h0000_0500, 32'h0000_0024, 5'd0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7]  = '{4'd0, 3'd1, 32'h0000_0003, 32'h0000_0500, 32'h0000_0024, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0003};
        vecs[8]  = '{4'd0, 3'd3, 32'h0000_0000, 32'h0000_0900, 32'h0000_0100, 5'd1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0104};
        vecs[9]  = '{4'd3, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_0000, 5'd3,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{4'd7, 3'd0, 32'h0000_0201, 32'h0,        32'h0000_0000, 5'd4,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{4'd5, 3'd0, 32'h0000_0003, 32'h0,        32'h0000_0000, 5'd8,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{4'd9, 3'd5, 32'h0000_0002, 32'h0000_0700, 32'h0000_0000, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0002};

        RST = 1'b1; me_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        applyStimulus(4'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0);
        me_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("reset wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        checkOutput("reset wb_err", {31'd0, wb_err}, 32'd0);
        checkOutput("reset wb_data", wb_data, 32'd0);
        checkOutput("reset wb_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("reset req_valid", {31'd0, dmem_req_valid}, 32'd0);
        RST = 1'b0;

        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].memop, vecs[v].brop, vecs[v].alu, vecs[v].bradd, vecs[v].pc,
                          vecs[v].rd, vecs[v].rw, vecs[v].sel, vecs[v].zero, 32'h0);
            #1;
            checkOutput($sformatf("vec%0d stall", v), {31'd0, me_stall}, 32'd0);
            checkOutput($sformatf("vec%0d br_taken", v), {31'd0, br_taken}, {31'd0, vecs[v].expBr});
            if (vecs[v].expBr) checkOutput($sformatf("vec%0d br_target", v), br_target, vecs[v].bradd);
            checkOutput($sformatf("vec%0d req_valid", v), {31'd0, dmem_req_valid}, 32'd0);
            @(posedge CLK); #1;
            checkOutput($sformatf("vec%0d wb_valid", v), {31'd0, wb_valid}, 32'd1);
            checkOutput($sformatf("vec%0d wb_rd", v), {27'd0, wb_rd}, {27'd0, vecs[v].rd});
            checkOutput($sformatf("vec%0d wb_regwrite", v), {31'd0, wb_regwrite}, {31'd0, vecs[v].expRw});
            checkOutput($sformatf("vec%0d wb_err", v), {31'd0, wb_err}, {31'd0, vecs[v].expErr});
            if (!vecs[v].expErr) checkOutput($sformatf("vec%0d wb_data", v), wb_data, vecs[v].expData);
        end
        me_valid = 1'b0;
        @(posedge CLK); #1;
        checkOutput("idle wb_valid", {31'd0, wb_valid}, 32'd0);

        memTxn("LB",  4'd1, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 2, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 2'd1, 32'hFFFF_FF80, 1'b1);
        memTxn("SH",  4'd7, 32'h0000_0202, 32'hABCD_1234, 32'h0, 3, 0, 32'h0000_0200, 1'b1, 4'b1100, 32'h1234_1234, 2'd0, 32'h0000_0202, 1'b0);
        memTxn("SB",  4'd6, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1, 1, 32'h0000_0200, 1'b1, 4'b0010, 32'hABAB_ABAB, 2'd0, 32'h0000_0201, 1'b0);
        memTxn("SW",  4'd8, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 0, 0, 32'h0000_0300, 1'b1, 4'b1111, 32'hCAFE_F00D, 2'd0, 32'h0000_0300, 1'b0);
        memTxn("LHU", 4'd5, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 0, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 2'd1, 32'h0000_80FF, 1'b1);
        memTxn("LH",  4'd2, 32'h0000_0100, 32'h0, 32'h1234_8001, 1, 0, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 2'd1, 32'hFFFF_8001, 1'b1);
        memTxn("LW",  4'd3, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'h0000_0104, 1'b0, 4'b1111, 32'h0, 2'd1, 32'hDEAD_BEEF, 1'b1);

        // Watchdog expiring in WAIT: accepted at once, no response ever.
        applyStimulus(4'd3, 3'd0, 32'h0000_0400, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1, 1'b0, 32'h0);
        dmem_req_ready = 1'b1;
        #1;
        checkOutput("towait issue stall", {31'd0, me_stall}, 32'd1);
        @(posedge CLK); #1;
        dmem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("towait c%0d stall", k), {31'd0, me_stall}, {31'd0, (k < 3)});
            @(posedge CLK); #1;
        end
        me_valid = 1'b0;
        checkOutput("towait wb_valid", {31'd0, wb_valid}, 32'd1);
        checkOutput("towait wb_err", {31'd0, wb_err}, 32'd1);
        checkOutput("towait wb_regwrite", {31'd0, wb_regwrite}, 32'd0);

        // Watchdog expiring in REQ: never accepted, request must drop on the timeout cycle.
        applyStimulus(4'd8, 3'd0, 32'h0000_0500, 32'h0, 32'h0, 5'd2, 1'b1, 2'd0, 1'b0, 32'h1111_2222);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("toreq c%0d stall", k), {31'd0, me_stall}, {31'd0, (k < 4)});
            checkOutput($sformatf("toreq c%0d reqvalid", k), {31'd0, dmem_req_valid}, {31'd0, (k < 4)});
            @(posedge CLK); #1;
        end
        me_valid = 1'b0;
        checkOutput("toreq wb_valid", {31'd0, wb_valid}, 32'd1);
        checkOutput("toreq wb_err", {31'd0, wb_err}, 32'd1);

        // Reset while WAIT: transaction abandoned, late response ignored.
        applyStimulus(4'd3, 3'd0, 32'h0000_0600, 32'h0, 32'h0, 5'd6, 1'b1, 2'd1, 1'b0, 32'h0);
        dmem_req_ready = 1'b1;
        @(posedge CLK); #1;
        dmem_req_ready = 1'b0;
        RST = 1'b1; me_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("rstwait req_valid", {31'd0, dmem_req_valid}, 32'd0);
        checkOutput("rstwait wb_valid", {31'd0, wb_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        @(posedge CLK); #1;
        checkOutput("rstwait late rsp wb_valid", {31'd0, wb_valid}, 32'd0);
        me_valid = 1'b1;
        #1;
        checkOutput("rstwait idle stall", {31'd0, me_stall}, 32'd1);
        checkOutput("rstwait idle reqvalid", {31'd0, dmem_req_valid}, 32'd1);
        RST = 1'b1; me_valid = 1'b0; dmem_rsp_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("final wb_valid", {31'd0, wb_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
